// File: rtl/bus_reg_unloader.sv
//------------------------------------------------------------------------------
// Module      : bus_reg_unloader
// Description : Captures three register values in parallel on a start request
//               and drains them onto a single bus in reverse order
//               (Reg3, Reg2, Reg1), one word per valid/ready handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_reg_unloader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] reg1_in,
  input  logic [WIDTH-1:0] reg2_in,
  input  logic [WIDTH-1:0] reg3_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] Reg1,
  output logic [WIDTH-1:0] Reg2,
  output logic [WIDTH-1:0] Reg3,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND3 = 2'b01,
    SEND2 = 2'b10,
    SEND1 = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_reg1;
  logic [WIDTH-1:0] r_reg2;
  logic [WIDTH-1:0] r_reg3;
  logic [WIDTH-1:0] w_reg1_nxt;
  logic [WIDTH-1:0] w_reg2_nxt;
  logic [WIDTH-1:0] w_reg3_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_xfer;

  // A word leaves the block only when it is offered and accepted together.
  assign w_xfer = r_valid & out_ready;

  // State, captured registers and the registered bus word update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_reg1  <= '0;
      r_reg2  <= '0;
      r_reg3  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_reg1  <= w_reg1_nxt;
      r_reg2  <= w_reg2_nxt;
      r_reg3  <= w_reg3_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decode: everything holds unless a start is taken in IDLE or
  // the offered word is accepted; done is a single-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_reg1_nxt  = r_reg1;
    w_reg2_nxt  = r_reg2;
    w_reg3_nxt  = r_reg3;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_reg1_nxt  = reg1_in;
          w_reg2_nxt  = reg2_in;
          w_reg3_nxt  = reg3_in;
          w_data_nxt  = reg3_in;
          w_valid_nxt = 1'b1;
          w_state_nxt = SEND3;
        end
      end
      SEND3: begin
        if (w_xfer) begin
          w_data_nxt  = r_reg2;
          w_state_nxt = SEND2;
        end
      end
      SEND2: begin
        if (w_xfer) begin
          w_data_nxt  = r_reg1;
          w_state_nxt = SEND1;
        end
      end
      SEND1: begin
        if (w_xfer) begin
          w_data_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign state     = r_state;
  assign Reg1      = r_reg1;
  assign Reg2      = r_reg2;
  assign Reg3      = r_reg3;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bus_reg_unloader.sv
//------------------------------------------------------------------------------
// Module      : tb_bus_reg_unloader
// Description : Directed self-checking bench for bus_reg_unloader with a
//               scoreboard queue of expected bus words.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_reg_unloader;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] reg1_in;
  logic [WIDTH-1:0] reg2_in;
  logic [WIDTH-1:0] reg3_in;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [1:0]       state;
  logic [WIDTH-1:0] Reg1;
  logic [WIDTH-1:0] Reg2;
  logic [WIDTH-1:0] Reg3;
  logic             busy;
  logic             done;

  int passes = 0;
  int total  = 0;
  logic [WIDTH-1:0] sb[$];

  bus_reg_unloader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg1_in   (reg1_in),
    .reg2_in   (reg2_in),
    .reg3_in   (reg3_in),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .state     (state),
    .Reg1      (Reg1),
    .Reg2      (Reg2),
    .Reg3      (Reg3),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_state);
    chk({tag, "_state"}, {30'd0, state}, {30'd0, exp_state});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (exp_state != 2'b00)});
  endtask

  // Called just after a falling edge with inputs settled: if a handshake will
  // happen at the coming rising edge, the offered word must match the
  // scoreboard head. Returns just after the next falling edge.
  task automatic clk_step();
    logic [WIDTH-1:0] exp_word;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {28'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        exp_word = sb.pop_front();
        chk("word", {28'd0, data_out}, {28'd0, exp_word});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                          input logic [WIDTH-1:0] r3);
    reg1_in = r1;
    reg2_in = r2;
    reg3_in = r3;
    sb.push_back(r3);
    sb.push_back(r2);
    sb.push_back(r1);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    reg1_in   = '0;
    reg2_in   = '0;
    reg3_in   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk_state("rst", 2'b00);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {28'd0, data_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_regs", {20'd0, Reg1, Reg2, Reg3}, 32'd0);
    rst = 1'b1;
    clk_step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Basic drain 9,7,8 -> 8,7,9
    push_seq(4'd9, 4'd7, 4'd8);
    start = 1'b1;
    out_ready = 1'b1;
    clk_step();
    start = 1'b0;
    chk_state("b_s3", 2'b01);
    chk("b_valid", {31'd0, out_valid}, 32'd1);
    chk("b_data3", {28'd0, data_out}, 32'd8);
    clk_step();
    chk_state("b_s2", 2'b10);
    clk_step();
    chk_state("b_s1", 2'b11);
    clk_step();
    chk_state("b_end", 2'b00);
    chk("b_done", {31'd0, done}, 32'd1);
    chk("b_valid0", {31'd0, out_valid}, 32'd0);
    chk("b_data0", {28'd0, data_out}, 32'd0);
    clk_step();
    chk("b_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure in SEND2
    push_seq(4'd9, 4'd7, 4'd8);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      chk_state("bp_hold", 2'b10);
      chk("bp_data", {28'd0, data_out}, 32'd7);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    clk_step();
    chk("bp_data1", {28'd0, data_out}, 32'd9);
    clk_step();
    chk("bp_done", {31'd0, done}, 32'd1);
    clk_step();

    // Start while busy is ignored
    push_seq(4'd9, 4'd7, 4'd8);
    start = 1'b1;
    out_ready = 1'b0;
    clk_step();
    reg1_in = 4'hF;
    reg2_in = 4'hF;
    reg3_in = 4'hF;
    clk_step();
    chk("sb_regs", {20'd0, Reg1, Reg2, Reg3}, {20'd0, 4'd9, 4'd7, 4'd8});
    chk_state("sb_s3", 2'b01);
    out_ready = 1'b1;
    clk_step();
    clk_step();
    chk("sb_regs2", {20'd0, Reg1, Reg2, Reg3}, {20'd0, 4'd9, 4'd7, 4'd8});
    start = 1'b0;
    clk_step();
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_gap", {31'd0, out_valid}, 32'd0);

    // Back-to-back: start in the done cycle
    push_seq(4'd1, 4'd2, 4'd3);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    chk("bb_valid", {31'd0, out_valid}, 32'd1);
    chk("bb_data", {28'd0, data_out}, 32'd3);
    chk_state("bb_s3", 2'b01);
    clk_step();
    clk_step();
    clk_step();
    chk("bb_done", {31'd0, done}, 32'd1);

    // Width extremes F,0,A -> A,0,F
    push_seq(4'hF, 4'h0, 4'hA);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    chk("w_data3", {28'd0, data_out}, 32'hA);
    clk_step();
    chk("w_data2", {28'd0, data_out}, 32'h0);
    chk("w_valid2", {31'd0, out_valid}, 32'd1);
    clk_step();
    chk("w_data1", {28'd0, data_out}, 32'hF);
    clk_step();
    chk("w_done", {31'd0, done}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    clk_step();

    // Asynchronous reset mid-cycle in SEND2
    push_seq(4'd9, 4'd7, 4'd8);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    chk_state("ar_pre", 2'b10);
    #2;
    rst = 1'b0;
    #1;
    chk_state("ar", 2'b00);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data", {28'd0, data_out}, 32'd0);
    chk("ar_regs", {20'd0, Reg1, Reg2, Reg3}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    clk_step();
    chk_state("ar_idle", 2'b00);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
